// File: rtl/ksa_pkg.sv
// Shared constants and types for the pipelined Kogge-Stone subtractor.
package ksa_pkg;

  localparam int KSA_WIDTH = 24;
  localparam int KSA_LO_W  = 12;

  typedef logic [KSA_WIDTH-1:0] ksa_word_t;

  typedef struct packed {
    ksa_word_t d;
    logic      borrow;
    logic      zero;
  } ksa_sub_res_t;

endpackage

// File: rtl/ksa_prefix_slice.sv
// Parameterised-width Kogge-Stone carry network: sum = a + b_inv + cin, with carry-out.
module ksa_prefix_slice #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LVLS = $clog2(W);

  always_comb begin
    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    p0 = a ^ b_inv;
    g  = a & b_inv;
    p  = p0;
    // Fold the carry-in into bit 0 so every prefix g[i] is the carry into bit i+1.
    g[0] = g[0] | (p0[0] & cin);
    for (int k = 0; k < LVLS; k++) begin
      gn = g;
      pn = p;
      for (int i = (1 << k); i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-(1<<k)]);
        pn[i] = p[i] & p[i-(1<<k)];
      end
      g = gn;
      p = pn;
    end
    sum  = p0 ^ {g[W-2:0], cin};
    cout = g[W-1];
  end

endmodule

// File: rtl/ksa_sub_pipe.sv
// Two-stage 24-bit Kogge-Stone subtractor D = A - B - bin, split at LO_W,
// with a valid/ready skid-free pipeline sustaining one beat per cycle.
module ksa_sub_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_d,
  output logic             o_borrow,
  output logic             o_zero
);

  localparam int HI_W = WIDTH - LO_W;

  // Handshake: a beat transfers on a clock edge where valid & ready are both high.
  // o_ready depends only on pipeline occupancy and i_ready, never on i_valid.
  logic adv1;
  logic adv2;

  logic              s1_valid_q, s1_valid_d;
  logic [LO_W-1:0]   d_lo_q, d_lo_d;
  logic              b_lo_q, b_lo_d;
  logic              z_lo_q, z_lo_d;
  logic [HI_W-1:0]   a_hi_q, a_hi_d;
  logic [HI_W-1:0]   b_hi_q, b_hi_d;

  logic              s2_valid_q, s2_valid_d;
  ksa_sub_res_t      res_q, res_d;

  logic [LO_W-1:0]   sum_lo;
  logic              cout_lo;
  logic [HI_W-1:0]   sum_hi;
  logic              cout_hi;

  assign adv2    = !s2_valid_q | i_ready;
  assign adv1    = !s1_valid_q | adv2;
  assign o_ready = adv1;

  ksa_prefix_slice #(.W(LO_W)) u_lo (
    .a     (i_a[LO_W-1:0]),
    .b_inv (~i_b[LO_W-1:0]),
    .cin   (~i_bin),
    .sum   (sum_lo),
    .cout  (cout_lo)
  );

  // Upper slice: the stored low-slice borrow becomes an inverted carry-in.
  ksa_prefix_slice #(.W(HI_W)) u_hi (
    .a     (a_hi_q),
    .b_inv (~b_hi_q),
    .cin   (~b_lo_q),
    .sum   (sum_hi),
    .cout  (cout_hi)
  );

  always_comb begin
    s1_valid_d = adv1 ? i_valid : s1_valid_q;
    d_lo_d     = d_lo_q;
    b_lo_d     = b_lo_q;
    z_lo_d     = z_lo_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    if (adv1 && i_valid) begin
      d_lo_d = sum_lo;
      b_lo_d = ~cout_lo;
      z_lo_d = (sum_lo == '0);
      a_hi_d = i_a[WIDTH-1:LO_W];
      b_hi_d = i_b[WIDTH-1:LO_W];
    end
  end

  always_comb begin
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    res_d      = res_q;
    if (adv2 && s1_valid_q) begin
      res_d.d      = {sum_hi, d_lo_q};
      res_d.borrow = ~cout_hi;
      res_d.zero   = z_lo_q & (sum_hi == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
    end
  end

  // Stage-1 payload carries no reset; it is qualified by s1_valid_q.
  always_ff @(posedge clock) begin
    d_lo_q <= d_lo_d;
    b_lo_q <= b_lo_d;
    z_lo_q <= z_lo_d;
    a_hi_q <= a_hi_d;
    b_hi_q <= b_hi_d;
  end

  assign o_valid  = s2_valid_q;
  assign o_d      = res_q.d;
  assign o_borrow = res_q.borrow;
  assign o_zero   = res_q.zero;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe: directed vectors, backpressure, mid-stream reset, random stream.
module tb_ksa_sub_pipe;

  localparam int W = 24;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_bin;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_d;
  logic         o_borrow;
  logic         o_zero;

  int checks   = 0;
  int errors   = 0;
  int recv_cnt = 0;

  // Entry layout: {borrow, zero, d}
  logic [W+1:0] exp_q[$];

  ksa_sub_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_bin    (i_bin),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_d      (o_d),
    .o_borrow (o_borrow),
    .o_zero   (o_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0] diff;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return {diff[W], (diff[W-1:0] == '0), diff[W-1:0]};
  endfunction

  // Scoreboard: push on accept, pop and compare on result transfer.
  always @(negedge clock) begin
    logic [W+1:0] exp;
    logic [W+1:0] got;
    if (!reset) begin
      if (i_valid && o_ready) exp_q.push_back(model(i_a, i_b, i_bin));
      if (o_valid && i_ready) begin
        got = {o_borrow, o_zero, o_d};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected got=%h required=none", got);
        end else begin
          exp = exp_q.pop_front();
          recv_cnt++;
          if (got !== exp) begin
            errors++;
            $display("FAIL result got {b,z,d}=%h required=%h", got, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int   t;
    logic ok;
    t = 0;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_bin = bin;
    do begin
      @(negedge clock);
      ok = o_ready;
      @(posedge clock);
      t++;
    end while (!ok && t < 200);
    #1;
    i_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout o_ready=%b required=1", ok);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    i_ready = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a = '0;
    i_b = '0;
    i_bin = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks += 5;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b required=0", o_valid); end
    if (o_d !== '0) begin errors++; $display("FAIL reset_o_d got=%h required=0", o_d); end
    if (o_borrow !== 1'b0) begin errors++; $display("FAIL reset_o_borrow got=%b required=0", o_borrow); end
    if (o_zero !== 1'b0) begin errors++; $display("FAIL reset_o_zero got=%b required=0", o_zero); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got=%b required=1", o_ready); end
  endtask

  task automatic test_directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input logic [W-1:0] exp_d, input logic exp_b, input logic exp_z);
    int lat;
    i_ready = 1'b1;
    send(a, b, bin);
    lat = 1;
    while (!o_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks += 4;
    if (lat != 2) begin errors++; $display("FAIL latency got=%0d required=2", lat); end
    if (o_d !== exp_d) begin errors++; $display("FAIL dir_d a=%h b=%h got=%h required=%h", a, b, o_d, exp_d); end
    if (o_borrow !== exp_b) begin errors++; $display("FAIL dir_borrow a=%h b=%h got=%b required=%b", a, b, o_borrow, exp_b); end
    if (o_zero !== exp_z) begin errors++; $display("FAIL dir_zero a=%h b=%h got=%b required=%b", a, b, o_zero, exp_z); end
    drain();
  endtask

  task automatic test_backpressure();
    int           base;
    logic         dropped;
    logic [W+1:0] hold;
    base = recv_cnt;
    dropped = 1'b0;
    i_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(W'($urandom_range(0, 24'hFFFFFF)), W'($urandom_range(0, 24'hFFFFFF)), 1'($urandom_range(0, 1)));
      end
      begin
        tick();
        tick();
        i_ready = 1'b0;
        @(negedge clock);
        if (!o_ready) dropped = 1'b1;
        hold = {o_borrow, o_zero, o_d};
        for (int c = 0; c < 4; c++) begin
          @(negedge clock);
          if (!o_ready) dropped = 1'b1;
          checks++;
          if (o_valid !== 1'b1 || {o_borrow, o_zero, o_d} !== hold) begin
            errors++;
            $display("FAIL stall_hold got v=%b %h required v=1 %h", o_valid, {o_borrow, o_zero, o_d}, hold);
          end
        end
        @(posedge clock);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    checks += 2;
    if (dropped !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got=%b required=1", dropped); end
    if (recv_cnt - base != 6) begin errors++; $display("FAIL bp_count got=%0d required=6", recv_cnt - base); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    send(24'h123456, 24'h000111, 1'b0);
    send(24'h000001, 24'h000002, 1'b1);
    reset = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_o_valid got=%b required=0", o_valid); end
    exp_q.delete();
    reset = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale got=%b required=0", o_valid); end
      tick();
    end
    test_directed(24'h222222, 24'h111111, 1'b0, 24'h111111, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic done;
    int   base;
    done = 1'b0;
    base = recv_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0: send(W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
            1: send(24'h001000, W'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            default: send(W'($urandom_range(0, 24'hFFFFFF)), W'($urandom_range(0, 24'hFFFFFF)), 1'($urandom_range(0, 1)));
          endcase
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          i_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain();
    checks++;
    if (recv_cnt - base != 40) begin errors++; $display("FAIL rand_count got=%0d required=40", recv_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_directed(24'h222222, 24'h111111, 1'b0, 24'h111111, 1'b0, 1'b0);
    test_directed(24'hABABAB, 24'hBCBCBC, 1'b0, 24'hEEEEEF, 1'b1, 1'b0);
    test_directed(24'hBCBCBC, 24'hABABAB, 1'b0, 24'h111111, 1'b0, 1'b0);
    test_directed(24'h001000, 24'h000001, 1'b0, 24'h000FFF, 1'b0, 1'b0);
    test_directed(24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);
    test_directed(24'h5A5A5A, 24'h5A5A5A, 1'b0, 24'h000000, 1'b0, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ksa_sub_pipe.md
Name: ksa_sub_pipe

Overview:
- Pipelined 24-bit Kogge-Stone subtractor computing D = A - B - bin. It is the inverse-direction companion to the 24-bit Kogge-Stone adder.
- Serves mantissa alignment/normalisation paths that need an exact difference plus borrow.
- Two register stages, split at bit 12. A valid/ready handshake provides full backpressure and sustains one result per cycle.

Parameters:
- WIDTH, 24, operand/result width; must be even.
- LO_W, WIDTH/2, width of the low slice resolved in stage 1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block can accept an operand beat this cycle.
- i_a  input  WIDTH  minuend, unsigned.
- i_b  input  WIDTH  subtrahend, unsigned.
- i_bin  input  1  borrow-in.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result beat.
- o_d  output  WIDTH  difference, (A - B - bin) mod 2^WIDTH.
- o_borrow  output  1  1 iff A < B + bin (unsigned).
- o_zero  output  1  1 iff o_d == 0.

Behaviour:
- Arithmetic:
  - D = A + ~B + ~bin, with the prefix network carry-in = ~i_bin.
  - Borrow out = ~carry out.
  - All unsigned; no overflow flag.
- Stage 1 (s1), on accept (i_valid & o_ready):
  - Registers low LO_W bits of D.
  - Registers the low-slice borrow b_lo.
  - Registers upper A and B bits unmodified.
  - Sets s1_valid.
- Stage 2 (s2), when s1 advances:
  - Computes upper WIDTH-LO_W bits with borrow-in b_lo.
  - Registers o_d, o_borrow and o_zero (o_zero = low slice zero AND upper slice zero).
  - Sets s2_valid.
- Handshake:
  - s2 advance condition: adv2 = !s2_valid | i_ready.
  - s1 advance condition: adv1 = !s1_valid | adv2.
  - o_ready = adv1, combinational from i_ready; no combinational path from i_valid.
  - o_valid = s2_valid.
- Latency: result appears on o_valid 2 cycles after accept when unstalled. Throughput is 1 beat/cycle.
- Stall: while o_valid & !i_ready, o_d, o_borrow and o_zero hold stable. s1 holds if full; o_ready drops only when both stages are full.
- Simultaneous accept and drain with both stages full: all beats shift by one, no bubble, no loss.
- Payload registers load only on advance; no data-reset requirement.
- Reset:
  - s1_valid = s2_valid = 0 next cycle.
  - o_valid = 0, o_d = 0, o_borrow = 0, o_zero = 0.
  - Reset mid-operation discards in-flight beats.
  - o_ready = 1 from the first cycle after reset deasserts.
- Beat ordering is strictly preserved.

Decomposition:
- Package ksa_pkg:
  - constants KSA_WIDTH = 24 and KSA_LO_W = 12.
  - typedef ksa_word_t (logic [KSA_WIDTH-1:0]).
  - struct ksa_sub_res_t {d, borrow, zero}.
- One sub-module, ksa_prefix_slice: parameterised-width Kogge-Stone carry network.
  - Inputs: a, b_inv, cin.
  - Outputs: sum, cout.
  - Instantiated twice: low slice in s1, high slice in s2.

Test Plan:
- A=222222h, B=111111h, bin=0 -> after 2 cycles D=111111h, borrow=0, zero=0.
- A=ABABABh, B=BCBCBCh, bin=0 -> D=EEEEEFh, borrow=1. Then A=BCBCBCh, B=ABABABh -> D=111111h, borrow=0.
- Boundary borrow across the 12-bit split: A=001000h, B=000001h -> D=000FFFh, borrow=0.
- Boundary borrow across the 12-bit split: A=000000h, B=000000h, bin=1 -> D=FFFFFFh, borrow=1, zero=0.
- Zero detection: A=B=5A5A5Ah, bin=0 -> D=000000h, zero=1, borrow=0.
- Backpressure:
  - Stream 6 back-to-back beats with i_ready held low for cycles 3-7.
  - o_ready must drop once 2 beats are buffered.
  - Outputs must hold stable throughout the stall.
  - All 6 results must arrive in order with no drop or duplicate.
- Reset mid-stream with 2 beats in flight -> o_valid=0 next cycle; no stale beat ever emerges; first post-reset beat arrives with 2-cycle latency.
